// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 8-requester round-robin mux arbiter.
// Pick function scans from a start pointer; fixed priority reuses it with pointer 0.
package mux_arb_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DATA_W = 4;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // First set bit of req scanning ptr, ptr+1, ... ptr+7 (mod 8).
    function automatic sel_t rr_pick(input logic [N_REQ-1:0] req, input sel_t ptr);
        sel_t pick;
        sel_t idx;
        pick = ptr;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [N_REQ-1:0] sel_onehot(input sel_t s);
        return N_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/mux8_4bits.sv
// Combinational 8-to-1 word mux shared by the arbiter's requesters.
module mux8_4bits #(
    parameter int unsigned DW = 4
) (
    input  logic [DW-1:0] D0,
    input  logic [DW-1:0] D1,
    input  logic [DW-1:0] D2,
    input  logic [DW-1:0] D3,
    input  logic [DW-1:0] D4,
    input  logic [DW-1:0] D5,
    input  logic [DW-1:0] D6,
    input  logic [DW-1:0] D7,
    input  logic [2:0]    sel,
    output logic [DW-1:0] Y
);

    always_comb begin
        Y = D0;
        case (sel)
            3'd0: Y = D0;
            3'd1: Y = D1;
            3'd2: Y = D2;
            3'd3: Y = D3;
            3'd4: Y = D4;
            3'd5: Y = D5;
            3'd6: Y = D6;
            3'd7: Y = D7;
            default: Y = D0;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning a shared 8:1 mux; forwards the winner's word over valid/ready.
// Define MUX_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
import mux_arb_pkg::*;

module mux8_rr_arbiter #(
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    req,
    input  logic [DW-1:0] D0,
    input  logic [DW-1:0] D1,
    input  logic [DW-1:0] D2,
    input  logic [DW-1:0] D3,
    input  logic [DW-1:0] D4,
    input  logic [DW-1:0] D5,
    input  logic [DW-1:0] D6,
    input  logic [DW-1:0] D7,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [2:0]    sel,
    output logic [7:0]    grant,
    output logic [7:0]    ack
);

    arb_state_t       state_q;
    sel_t             sel_q;
    logic [DW-1:0]    out_data_q;
    logic             out_valid_q;
    logic [N_REQ-1:0] grant_q;

    sel_t             winner;
    sel_t             mux_sel;
    logic [DW-1:0]    mux_y;
    logic             xfer;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign winner = rr_pick(req, '0);
`else
    sel_t ptr_q;
    assign winner = rr_pick(req, ptr_q);
`endif

    // Mux follows the live winner while arbitrating, then the frozen grant.
    assign mux_sel = (state_q == IDLE) ? winner : sel_q;
    assign xfer    = out_valid_q & out_ready;

    mux8_4bits #(.DW(DW)) u_mux (
        .D0  (D0),
        .D1  (D1),
        .D2  (D2),
        .D3  (D3),
        .D4  (D4),
        .D5  (D5),
        .D6  (D6),
        .D7  (D7),
        .sel (mux_sel),
        .Y   (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        sel_q       <= winner;
                        out_data_q  <= mux_y;
                        out_valid_q <= 1'b1;
                        grant_q     <= sel_onehot(winner);
                        state_q     <= BUSY;
                    end else begin
                        out_valid_q <= 1'b0;
                        grant_q     <= '0;
                    end
                end
                BUSY: begin
                    // Pointer only advances when the word is actually consumed.
                    if (xfer) begin
`ifndef MUX_ARB_FIXED_PRIO_EN
                        ptr_q       <= sel_q + SEL_W'(1);
`endif
                        out_valid_q <= 1'b0;
                        grant_q     <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (xfer) begin
            ack = sel_onehot(sel_q);
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter (either arbitration build).
`timescale 1ns/1ps

module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       out_ready;
    logic [7:0] req;
    logic [3:0] d [8];
    logic       out_valid;
    logic [3:0] out_data;
    logic [2:0] sel;
    logic [7:0] grant;
    logic [7:0] ack;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] sweep_vals [8] = '{4'h6, 4'hB, 4'h2, 4'h7, 4'h8, 4'hF, 4'hC, 4'hA};

    mux8_rr_arbiter #(.DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .D0        (d[0]),
        .D1        (d[1]),
        .D2        (d[2]),
        .D3        (d[3]),
        .D4        (d[4]),
        .D5        (d[5]),
        .D6        (d[6]),
        .D7        (d[7]),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .grant     (grant),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sweep_idx(input int k);
`ifdef MUX_ARB_FIXED_PRIO_EN
        return 0;
`else
        return k % 8;
`endif
    endfunction

    initial begin
        int idx;
        rst_n     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) d[i] = sweep_vals[i];

        // Reset holds everything clear despite full request vector
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sel",   32'(sel),       32'd0);
        check("rst_grant", 32'(grant),     32'd0);
        check("rst_ack",   32'(ack),       32'd0);
        check("rst_data",  32'(out_data),  32'd0);

        // Release; sweep with req=FF held and consumer always ready
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            idx = sweep_idx(k);
            check("sw_valid", 32'(out_valid), 32'd1);
            check("sw_sel",   32'(sel),       32'(idx));
            check("sw_data",  32'(out_data),  32'(sweep_vals[idx]));
            check("sw_grant", 32'(grant),     32'(8'h01 << idx));
            check("sw_ack",   32'(ack),       32'(8'h01 << idx));
            if (k == 8) req = 8'h00;
            step();
            check("sw_bubble_valid", 32'(out_valid), 32'd0);
            check("sw_bubble_ack",   32'(ack),       32'd0);
        end
        step();

        // Single request from requester 3
        d[3] = 4'h7;
        req  = 8'h08;
        step();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_sel",   32'(sel),       32'd3);
        check("single_data",  32'(out_data),  32'h7);
        check("single_grant", 32'(grant),     32'h08);
        check("single_ack",   32'(ack),       32'h08);
        req = 8'h00;
        step();
        check("single_drop_valid", 32'(out_valid), 32'd0);
        check("single_drop_grant", 32'(grant),     32'd0);

        // Backpressure: word and grant frozen, data change ignored
        out_ready = 1'b0;
        d[5]      = 4'hF;
        req       = 8'h20;
        step();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_sel",   32'(sel),       32'd5);
        check("bp_data",  32'(out_data),  32'hF);
        check("bp_ack",   32'(ack),       32'd0);
        d[5] = 4'h0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data",  32'(out_data),  32'hF);
            check("bp_hold_grant", 32'(grant),     32'h20);
            check("bp_hold_ack",   32'(ack),       32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ack_pulse", 32'(ack), 32'h20);
        req = 8'h00;
        step();
        check("bp_ack_after", 32'(ack),       32'd0);
        check("bp_valid_after", 32'(out_valid), 32'd0);

        // Grant 7, then pointer wraps so 0 beats 7
        d[7] = 4'hA;
        req  = 8'h80;
        step();
        check("wrap7_sel", 32'(sel), 32'd7);
        check("wrap7_ack", 32'(ack), 32'h80);
        req = 8'h00;
        step();
        check("wrap7_done", 32'(out_valid), 32'd0);
        req = 8'h81;
        step();
        check("wrap_first_sel",  32'(sel),      32'd0);
        check("wrap_first_data", 32'(out_data), 32'h6);
        req = 8'h80;
        step();
        check("wrap_bubble", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        step();
        check("wrap_second_sel",   32'(sel),       32'd7);
        check("wrap_second_valid", 32'(out_valid), 32'd1);

        // Async reset mid-BUSY clears immediately without an edge
        out_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_grant", 32'(grant),     32'd0);
        check("arst_sel",   32'(sel),       32'd0);
        check("arst_ack",   32'(ack),       32'd0);
        check("arst_data",  32'(out_data),  32'd0);
        req = 8'h00;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
